// File: rtl/frame_max_min_sched.sv
// -----------------------------------------------------------------------------
// frame_max_min_sched
//
// Frame-level scheduler for a single FP32 pairwise max/min compare unit.
// Samples of one frame arrive over a valid/ready handshake. They are taken
// two at a time (A, B), and the external compare unit is time-multiplexed
// to produce the frame's largest and smallest magnitude. The compare unit
// strips the sign bit, so both results always have bit 31 clear. This
// controller does no float arithmetic itself.
//
// Schedule for one pair, with no stalls:
//   GET_A, GET_B, CMP_PAIR, CMP_MAX, CMP_MIN
// The first pair of a frame skips CMP_MAX and CMP_MIN, because its pair
// results seed the running max/min directly. An odd tail sample is paired
// with itself.
//
// Each CMP state holds the compare operands constant with cmp_ena high for
// CMP_LAT+1 cycles. It samples cmp_max/cmp_min on the last of those cycles,
// then drops cmp_ena (operands forced to 0) for one flush cycle.
//
// Optional build macro:
//   MAXMIN_NAN_FILTER_EN - when defined, an accepted NaN sample is replaced
//                          by +0.0 before it is stored, and the extra output
//                          nan_cnt counts the NaNs seen in the current frame.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start, frame_len  begin a frame (honoured only in IDLE); sample count
//   s_valid, s_ready, s_data   sample stream handshake
//   cmp_ena, cmp_in_1, cmp_in_2   drive to the compare unit
//   cmp_max, cmp_min  results from the compare unit
//   busy              high from the cycle after an accepted start until done
//   done              one-cycle pulse; max_out/min_out valid from this cycle
//   max_out, min_out  frame max/min magnitude, held until the next done
//   nan_cnt           (MAXMIN_NAN_FILTER_EN only) NaNs counted in the frame
// -----------------------------------------------------------------------------
module frame_max_min_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 10,
  parameter int CMP_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      frame_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  cmp_ena,
  output logic [DATA_WIDTH-1:0] cmp_in_1,
  output logic [DATA_WIDTH-1:0] cmp_in_2,
  input  logic [DATA_WIDTH-1:0] cmp_max,
  input  logic [DATA_WIDTH-1:0] cmp_min,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] max_out,
  output logic [DATA_WIDTH-1:0] min_out
`ifdef MAXMIN_NAN_FILTER_EN
  ,
  output logic [LEN_W-1:0]      nan_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    CMP_PAIR = 3'd3,
    CMP_MAX  = 3'd4,
    CMP_MIN  = 3'd5,
    FIN      = 3'd6
  } state_e;

  // Sub-cycle counter inside a CMP state: 0..CMP_LAT with the unit enabled,
  // then CMP_LAT+1 as the flush cycle.
  localparam int               CNT_W     = $clog2(CMP_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CMP_LAT);
  localparam logic [CNT_W-1:0] CNT_FLUSH = CNT_W'(CMP_LAT + 1);

  state_e                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [LEN_W-1:0]      rem_q,     rem_d;
  logic                  first_q,   first_d;
  logic [DATA_WIDTH-1:0] a_q,       a_d;
  logic [DATA_WIDTH-1:0] b_q,       b_d;
  logic [DATA_WIDTH-1:0] pmax_q,    pmax_d;
  logic [DATA_WIDTH-1:0] pmin_q,    pmin_d;
  logic [DATA_WIDTH-1:0] rmax_q,    rmax_d;
  logic [DATA_WIDTH-1:0] rmin_q,    rmin_d;
  logic [DATA_WIDTH-1:0] max_out_q, max_out_d;
  logic [DATA_WIDTH-1:0] min_out_q, min_out_d;
  logic                  done_q,    done_d;

  // Sample as it will be stored after optional NaN filtering.
  logic [DATA_WIDTH-1:0] sample;

`ifdef MAXMIN_NAN_FILTER_EN
  logic             sample_nan;
  logic [LEN_W-1:0] nan_cnt_q, nan_cnt_d;

  assign sample_nan = (s_data[30:23] == 8'hFF) && (s_data[22:0] != 23'd0);
  assign sample     = sample_nan ? '0 : s_data;
  assign nan_cnt    = nan_cnt_q;
`else
  assign sample = s_data;
`endif

  // Unit enabled for this CMP cycle / last enabled cycle (results sampled).
  logic cmp_run;
  logic cmp_take;

  assign cmp_run  = (cnt_q != CNT_FLUSH);
  assign cmp_take = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch
    // leaves one unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    first_d   = first_q;
    a_d       = a_q;
    b_d       = b_q;
    pmax_d    = pmax_q;
    pmin_d    = pmin_q;
    rmax_d    = rmax_q;
    rmin_d    = rmin_q;
    max_out_d = max_out_q;
    min_out_d = min_out_q;
    done_d    = 1'b0;
    s_ready   = 1'b0;
    cmp_ena   = 1'b0;
    cmp_in_1  = '0;
    cmp_in_2  = '0;
`ifdef MAXMIN_NAN_FILTER_EN
    nan_cnt_d = nan_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        // While done is high the FSM is already back in IDLE. A start in
        // that same cycle must still be ignored.
        if (start && !done_q) begin
          rem_d   = frame_len;
          first_d = 1'b1;
          cnt_d   = '0;
          rmax_d  = '0;
          rmin_d  = '0;
`ifdef MAXMIN_NAN_FILTER_EN
          nan_cnt_d = '0;
`endif
          state_d = (frame_len == '0) ? FIN : GET_A;
        end
      end

      GET_A: begin
        s_ready = 1'b1;
        if (s_valid) begin
          a_d   = sample;
          rem_d = rem_q - LEN_W'(1);
`ifdef MAXMIN_NAN_FILTER_EN
          if (sample_nan) nan_cnt_d = nan_cnt_q + LEN_W'(1);
`endif
          if (rem_q == LEN_W'(1)) begin
            // Odd tail: compare the last sample against itself.
            b_d     = sample;
            cnt_d   = '0;
            state_d = CMP_PAIR;
          end else begin
            state_d = GET_B;
          end
        end
      end

      GET_B: begin
        s_ready = 1'b1;
        if (s_valid) begin
          b_d   = sample;
          rem_d = rem_q - LEN_W'(1);
`ifdef MAXMIN_NAN_FILTER_EN
          if (sample_nan) nan_cnt_d = nan_cnt_q + LEN_W'(1);
`endif
          cnt_d   = '0;
          state_d = CMP_PAIR;
        end
      end

      CMP_PAIR: begin
        if (cmp_run) begin
          cmp_ena  = 1'b1;
          cmp_in_1 = a_q;
          cmp_in_2 = b_q;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cmp_take) begin
            pmax_d = cmp_max;
            pmin_d = cmp_min;
            // The first pair of a frame seeds the running results directly.
            if (first_q) begin
              rmax_d = cmp_max;
              rmin_d = cmp_min;
            end
          end
        end else begin
          cnt_d = '0;
          if (first_q) begin
            first_d = 1'b0;
            state_d = (rem_q != '0) ? GET_A : FIN;
          end else begin
            state_d = CMP_MAX;
          end
        end
      end

      CMP_MAX: begin
        if (cmp_run) begin
          cmp_ena  = 1'b1;
          cmp_in_1 = pmax_q;
          cmp_in_2 = rmax_q;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cmp_take) rmax_d = cmp_max;
        end else begin
          cnt_d   = '0;
          state_d = CMP_MIN;
        end
      end

      CMP_MIN: begin
        if (cmp_run) begin
          cmp_ena  = 1'b1;
          cmp_in_1 = pmin_q;
          cmp_in_2 = rmin_q;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cmp_take) rmin_d = cmp_min;
        end else begin
          cnt_d   = '0;
          state_d = (rem_q != '0) ? GET_A : FIN;
        end
      end

      FIN: begin
        max_out_d = rmax_q;
        min_out_d = rmin_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples its
    // pre-edge inputs regardless of statement order.
    if (rst) begin
      // A mid-frame reset abandons the frame, so the data registers and the
      // held results are cleared along with the control state.
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      pmax_q    <= '0;
      pmin_q    <= '0;
      rmax_q    <= '0;
      rmin_q    <= '0;
      max_out_q <= '0;
      min_out_q <= '0;
      done_q    <= 1'b0;
`ifdef MAXMIN_NAN_FILTER_EN
      nan_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pmax_q    <= pmax_d;
      pmin_q    <= pmin_d;
      rmax_q    <= rmax_d;
      rmin_q    <= rmin_d;
      max_out_q <= max_out_d;
      min_out_q <= min_out_d;
      done_q    <= done_d;
`ifdef MAXMIN_NAN_FILTER_EN
      nan_cnt_q <= nan_cnt_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign max_out = max_out_q;
  assign min_out = min_out_q;

endmodule

// File: tb/tb_frame_max_min_sched.sv
// -----------------------------------------------------------------------------
// tb_frame_max_min_sched
//
// Self-checking bench for frame_max_min_sched. It contains a behavioural
// model of the external compare unit: a CMP_LAT-deep delay line that
// produces sign-stripped max/min. While cmp_ena is low it shifts in junk, so
// results are only correct when taken at the right time.
//
// The frame-level expectations are computed directly from the sample set:
//   - the largest and smallest magnitude, and
//   - a closed-form latency for a stall-free frame.
// A single monitor on the falling edge compares the DUT against them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_max_min_sched;

  localparam int DW = 32;
  localparam int LW = 10;
  localparam int CL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          cmp_ena;
  logic [DW-1:0] cmp_in_1;
  logic [DW-1:0] cmp_in_2;
  logic [DW-1:0] cmp_max;
  logic [DW-1:0] cmp_min;
  logic          busy;
  logic          done;
  logic [DW-1:0] max_out;
  logic [DW-1:0] min_out;
`ifdef MAXMIN_NAN_FILTER_EN
  logic [LW-1:0] nan_cnt;
`endif

  always #5 clk = ~clk;

  frame_max_min_sched #(.DATA_WIDTH(DW), .LEN_W(LW), .CMP_LAT(CL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .frame_len(frame_len),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .cmp_ena  (cmp_ena),
    .cmp_in_1 (cmp_in_1),
    .cmp_in_2 (cmp_in_2),
    .cmp_max  (cmp_max),
    .cmp_min  (cmp_min),
    .busy     (busy),
    .done     (done),
    .max_out  (max_out),
`ifdef MAXMIN_NAN_FILTER_EN
    .nan_cnt  (nan_cnt),
`endif
    .min_out  (min_out)
  );

  // ---------------------------------------------------------------------------
  // Compare-unit model and helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mag(input logic [31:0] x);
    return {1'b0, x[30:0]};
  endfunction

  function automatic logic [31:0] filt(input logic [31:0] x);
`ifdef MAXMIN_NAN_FILTER_EN
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 32'h0;
`endif
    return x;
  endfunction

  logic [DW-1:0] max_pipe [CL];
  logic [DW-1:0] min_pipe [CL];

  always @(posedge clk) begin
    if (cmp_ena) begin
      max_pipe[0] <= (mag(cmp_in_1) >= mag(cmp_in_2)) ? mag(cmp_in_1) : mag(cmp_in_2);
      min_pipe[0] <= (mag(cmp_in_1) <= mag(cmp_in_2)) ? mag(cmp_in_1) : mag(cmp_in_2);
    end else begin
      max_pipe[0] <= 32'h5A5A_5A5A;
      min_pipe[0] <= 32'h2525_2525;
    end
    for (int i = 1; i < CL; i++) begin
      max_pipe[i] <= max_pipe[i-1];
      min_pipe[i] <= min_pipe[i-1];
    end
  end

  assign cmp_max = max_pipe[CL-1];
  assign cmp_min = min_pipe[CL-1];

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model state.
  logic [31:0] exp_max;
  logic [31:0] exp_min;
  bit          armed = 1'b0;

  task automatic arm_model(input logic [31:0] smp[$]);
    logic [31:0] m;
    exp_max = 32'h0;
    exp_min = 32'h0;
    foreach (smp[i]) begin
      m = mag(filt(smp[i]));
      if (i == 0) begin
        exp_max = m;
        exp_min = m;
      end else begin
        if (m > exp_max) exp_max = m;
        if (m < exp_min) exp_min = m;
      end
    end
    armed = 1'b1;
  endtask

  // Start-to-done latency of a stall-free frame:
  // - one GET cycle per sample;
  // - one CMP state for the first pair and three for every later pair,
  //   each lasting CL+2 cycles;
  // - FIN, then done one cycle later.
  function automatic int model_latency(input int len);
    int pairs;
    if (len == 0) return 2;
    pairs = (len + 1) / 2;
    return len + (CL + 2) * (3 * pairs - 2) + 2;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: the single compare process
  // ---------------------------------------------------------------------------
  int done_count   = 0;
  int done_cyc     = 0;
  int ready_cycles = 0;
  int hs_count     = 0;
  int frame_bursts = 0;
  int ena_run      = 0;
  int low_run      = 0;
  bit ena_prev     = 1'b0;
  int gaps[$];

  always @(negedge clk) begin
    if (rst) begin
      ena_prev = 1'b0;
      ena_run  = 0;
      low_run  = 0;
    end else begin
      if (s_ready) begin
        ready_cycles++;
        check("cmp_ena_low_in_get", cmp_ena, 1'b0);
        if (s_valid) hs_count++;
      end
      if (!cmp_ena) check("cmp_in_zero_when_disabled", cmp_in_1 | cmp_in_2, 32'h0);
      if (cmp_ena) begin
        if (!ena_prev) begin
          if (frame_bursts > 0) gaps.push_back(low_run);
          frame_bursts++;
        end
        ena_run++;
        low_run = 0;
      end else begin
        if (ena_prev) begin
          check("cmp_burst_len", ena_run, CL + 1);
          ena_run = 0;
        end
        low_run++;
      end
      ena_prev = cmp_ena;
      if (done) begin
        check("done_expected", armed, 1'b1);
        check("max_out", max_out, exp_max);
        check("min_out", min_out, exp_min);
        check("busy_low_at_done", busy, 1'b0);
        armed = 1'b0;
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int start_cyc = 0;
  int hs0       = 0;
  int rdy0      = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    frame_bursts = 0;
    gaps.delete();
    hs0       = hs_count;
    rdy0      = ready_cycles;
    start     = 1'b1;
    frame_len = LW'(len);
    start_cyc = cyc;
    tick();
    start     = 1'b0;
    frame_len = ~LW'(len);  // later changes must not affect the frame
  endtask

  task automatic feed(input logic [31:0] smp[$], input int gap);
    foreach (smp[i]) begin
      int guard;
      bit got;
      s_valid = 1'b1;
      s_data  = smp[i];
      got     = 1'b0;
      guard   = 0;
      while (!got && guard < 200) begin
        @(negedge clk);
        got = s_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      check("sample_accepted", got, 1'b1);
      s_valid = 1'b0;
      s_data  = 32'hDEAD_BEEF;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int k;
    n0 = done_count;
    k  = 0;
    while (done_count == n0 && k < budget) begin
      tick();
      k++;
    end
    check("done_arrived", done_count != n0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  logic [31:0] smp[$];
  int          n_before;
  int          guard;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    frame_len = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_s_ready", s_ready, 1'b0);
    check("reset_cmp_ena", cmp_ena, 1'b0);
    check("reset_max_out", max_out, 32'h0);
    check("reset_min_out", min_out, 32'h0);
    tick();

    // Even frame, no stalls; also pins latency and burst spacing.
    smp.delete();
    smp.push_back(32'h3F80_0000); smp.push_back(32'hC000_0000);
    smp.push_back(32'h3F00_0000); smp.push_back(32'h4040_0000);
    arm_model(smp);
    check("model_even_max", exp_max, 32'h4040_0000);
    check("model_even_min", exp_min, 32'h3F00_0000);
    start_frame(4);
    feed(smp, 0);
    wait_done(200);
    check("even_latency_model", done_cyc - start_cyc, model_latency(4));
    check("even_latency_literal", done_cyc - start_cyc, 26);
    check("even_handshakes", hs_count - hs0, 4);
    check("even_ready_cycles", ready_cycles - rdy0, 4);
    check("even_gap_count", gaps.size(), 3);
    if (gaps.size() == 3) begin
      check("even_gap0", gaps[0], 3);
      check("even_gap1", gaps[1], 1);
      check("even_gap2", gaps[2], 1);
    end
    repeat (3) tick();

    // Odd frame: the tail sample is paired with itself.
    smp.delete();
    smp.push_back(32'h3F80_0000); smp.push_back(32'hC000_0000);
    smp.push_back(32'h3F00_0000);
    arm_model(smp);
    check("model_odd_max", exp_max, 32'h4000_0000);
    start_frame(3);
    feed(smp, 0);
    wait_done(200);
    check("odd_latency_model", done_cyc - start_cyc, model_latency(3));
    check("odd_handshakes", hs_count - hs0, 3);
    repeat (3) tick();

    // Zero-length frame.
    smp.delete();
    arm_model(smp);
    start_frame(0);
    wait_done(20);
    check("zero_latency", done_cyc - start_cyc, 2);
    check("zero_no_ready", ready_cycles - rdy0, 0);
    repeat (3) tick();

    // Backpressure: even frame with 5-cycle s_valid gaps.
    smp.delete();
    smp.push_back(32'h3F80_0000); smp.push_back(32'hC000_0000);
    smp.push_back(32'h3F00_0000); smp.push_back(32'h4040_0000);
    arm_model(smp);
    start_frame(4);
    feed(smp, 5);
    wait_done(300);
    check("bp_handshakes", hs_count - hs0, 4);
    repeat (3) tick();

    // len=2 timing, and a start pulse in the same cycle as done.
    smp.delete();
    smp.push_back(32'h40A0_0000); smp.push_back(32'hBF80_0000);
    arm_model(smp);
    check("model_two_min", exp_min, 32'h3F80_0000);
    n_before = done_count;
    start_frame(2);
    feed(smp, 0);
    guard = 0;
    while (cyc < start_cyc + 9 && guard < 100) begin
      tick();
      guard++;
    end
    start     = 1'b1;
    frame_len = '0;
    tick();
    start = 1'b0;
    check("two_done_count", done_count, n_before + 1);
    check("two_latency_literal", done_cyc - start_cyc, 9);
    check("two_latency_model", done_cyc - start_cyc, model_latency(2));
    repeat (10) tick();
    check("start_at_done_ignored", done_count, n_before + 1);
    check("idle_after_ignored_start", busy, 1'b0);

    // Reset while in CMP_MAX of a frame.
    smp.delete();
    smp.push_back(32'h3F80_0000); smp.push_back(32'hC000_0000);
    smp.push_back(32'h3F00_0000); smp.push_back(32'h4040_0000);
    n_before = done_count;
    armed    = 1'b0;
    start_frame(4);
    feed(smp, 0);
    guard = 0;
    while (frame_bursts < 3 && guard < 100) begin
      tick();
      guard++;
    end
    check("reached_cmp_max", frame_bursts, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_max_out", max_out, 32'h0);
    check("rst_mid_min_out", min_out, 32'h0);
    check("rst_mid_busy", busy, 1'b0);
    repeat (30) tick();
    check("rst_mid_no_done", done_count, n_before);

    // New frame after reset, with start pulsed while busy.
    smp.delete();
    smp.push_back(32'h4120_0000); smp.push_back(32'h3DCC_CCCD);
    arm_model(smp);
    check("model_new_max", exp_max, 32'h4120_0000);
    check("model_new_min", exp_min, 32'h3DCC_CCCD);
    start_frame(2);
    feed(smp, 0);
    start     = 1'b1;
    frame_len = LW'(1);
    tick();
    start = 1'b0;
    wait_done(100);
    check("new_latency", done_cyc - start_cyc, 9);
    repeat (10) tick();
    check("busy_start_ignored", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
